algo_1r2w_a663_req_sched: RTL

- Request scheduler in front of the 1r2w a663 memory top wrapper.
- Shares the wrapper's two write slots and one read slot among NUMREQ requesters.
- Arbitrates round-robin, blocks same-cycle write/write and read/write address conflicts, and stalls until the memory reports ready.
- Tracks read-tag latency so each returned read is routed to the requester that issued it.

---
 rtl/algo_1r2w_a663_req_sched_if.sv | 44 ++++
 rtl/algo_1r2w_a663_req_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/algo_1r2w_a663_req_sched_if.sv
// Bundles the requester-side and memory-side buses of the 1r2w a663 request scheduler.
// The master modport is the environment (requesters plus memory wrapper); slave is the scheduler.
interface algo_1r2w_a663_req_sched_if #(
  parameter int NUMREQ  = 4,
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13
);
  logic [NUMREQ-1:0]         rq_write;
  logic [NUMREQ*BITADDR-1:0] rq_wr_adr;
  logic [NUMREQ*WIDTH-1:0]   rq_din;
  logic [NUMREQ-1:0]         rq_wr_gnt;
  logic [NUMREQ-1:0]         rq_read;
  logic [NUMREQ*BITADDR-1:0] rq_rd_adr;
  logic [NUMREQ-1:0]         rq_rd_gnt;
  logic [NUMREQ-1:0]         rq_rd_vld;
  logic [WIDTH-1:0]          rq_rd_dout;
  logic                      rq_rd_serr;
  logic                      rq_rd_derr;
  logic                      ready;
  logic [1:0]                write;
  logic [2*BITADDR-1:0]      wr_adr;
  logic [2*WIDTH-1:0]        din;
  logic                      read;
  logic [BITADDR-1:0]        rd_adr;
  logic                      rd_vld;
  logic [WIDTH-1:0]          rd_dout;
  logic                      rd_serr;
  logic                      rd_derr;
  logic                      tag_err;

  modport master (
    output rq_write, rq_wr_adr, rq_din, rq_read, rq_rd_adr,
    output ready, rd_vld, rd_dout, rd_serr, rd_derr,
    input  rq_wr_gnt, rq_rd_gnt, rq_rd_vld, rq_rd_dout, rq_rd_serr, rq_rd_derr,
    input  write, wr_adr, din, read, rd_adr, tag_err
  );

  modport slave (
    input  rq_write, rq_wr_adr, rq_din, rq_read, rq_rd_adr,
    input  ready, rd_vld, rd_dout, rd_serr, rd_derr,
    output rq_wr_gnt, rq_rd_gnt, rq_rd_vld, rq_rd_dout, rq_rd_serr, rq_rd_derr,
    output write, wr_adr, din, read, rd_adr, tag_err
  );
endinterface

// File: rtl/algo_1r2w_a663_req_sched.sv
// Round-robin scheduler sharing the two write slots and one read slot of the 1r2w a663 wrapper
// among NUMREQ requesters, with a tag pipe that routes each read return back to its issuer.
module algo_1r2w_a663_req_sched #(
  parameter int NUMREQ  = 4,
  parameter int BITREQ  = 2,
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int RD_LAT  = 3
) (
  input logic clk,
  input logic rst,
  algo_1r2w_a663_req_sched_if.slave bus
);

  logic [BITADDR-1:0] req_wr_adr [NUMREQ];
  logic [BITADDR-1:0] req_rd_adr [NUMREQ];
  logic [WIDTH-1:0]   req_din    [NUMREQ];

  for (genvar g = 0; g < NUMREQ; g++) begin : g_unpack
    assign req_wr_adr[g] = bus.rq_wr_adr[g*BITADDR +: BITADDR];
    assign req_rd_adr[g] = bus.rq_rd_adr[g*BITADDR +: BITADDR];
    assign req_din[g]    = bus.rq_din[g*WIDTH +: WIDTH];
  end

  // NUMREQ need not be a power of two, so wrap by comparing against the last index.
  function automatic logic [BITREQ-1:0] wrap_inc(input logic [BITREQ-1:0] v);
    return (v == BITREQ'(NUMREQ - 1)) ? '0 : v + BITREQ'(1);
  endfunction

  logic [BITREQ-1:0] wr_ptr, rd_ptr;
  logic [BITREQ-1:0] w_scan, r_scan;
  logic              w0_hit, w1_hit, r_hit;
  logic [BITREQ-1:0] w0_idx, w1_idx, r_idx, w_last;
  logic              arb_en;
  logic [NUMREQ-1:0] wr_gnt, rd_gnt;

  assign arb_en = bus.ready && !rst;
  assign w_last = w1_hit ? w1_idx : w0_idx;

  always_comb begin
    w0_hit = 1'b0;
    w1_hit = 1'b0;
    w0_idx = '0;
    w1_idx = '0;
    w_scan = wr_ptr;
    for (int k = 0; k < NUMREQ; k++) begin
      if (arb_en && bus.rq_write[w_scan]) begin
        if (!w0_hit) begin
          w0_hit = 1'b1;
          w0_idx = w_scan;
        end else if (!w1_hit && (req_wr_adr[w_scan] != req_wr_adr[w0_idx])) begin
          w1_hit = 1'b1;
          w1_idx = w_scan;
        end
      end
      w_scan = wrap_inc(w_scan);
    end
  end

  // A read that collides with either granted write address is deferred, not blocking later candidates.
  always_comb begin
    r_hit  = 1'b0;
    r_idx  = '0;
    r_scan = rd_ptr;
    for (int k = 0; k < NUMREQ; k++) begin
      if (arb_en && !r_hit && bus.rq_read[r_scan] &&
          !(w0_hit && (req_rd_adr[r_scan] == req_wr_adr[w0_idx])) &&
          !(w1_hit && (req_rd_adr[r_scan] == req_wr_adr[w1_idx]))) begin
        r_hit = 1'b1;
        r_idx = r_scan;
      end
      r_scan = wrap_inc(r_scan);
    end
  end

  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (w0_hit) wr_gnt[w0_idx] = 1'b1;
    if (w1_hit) wr_gnt[w1_idx] = 1'b1;
    if (r_hit)  rd_gnt[r_idx]  = 1'b1;
  end

  assign bus.rq_wr_gnt = wr_gnt;
  assign bus.rq_rd_gnt = rd_gnt;

  logic [1:0]           write_q;
  logic [2*BITADDR-1:0] wr_adr_q;
  logic [2*WIDTH-1:0]   din_q;
  logic                 read_q;
  logic [BITADDR-1:0]   rd_adr_q;

  // Unused write slots keep their last address/data so the memory bus only toggles on real writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      write_q  <= '0;
      wr_adr_q <= '0;
      din_q    <= '0;
      read_q   <= 1'b0;
      rd_adr_q <= '0;
    end else begin
      if (w0_hit) wr_ptr <= wrap_inc(w_last);
      if (r_hit)  rd_ptr <= wrap_inc(r_idx);
      write_q <= {w1_hit, w0_hit};
      if (w0_hit) begin
        wr_adr_q[0 +: BITADDR] <= req_wr_adr[w0_idx];
        din_q[0 +: WIDTH]      <= req_din[w0_idx];
      end
      if (w1_hit) begin
        wr_adr_q[BITADDR +: BITADDR] <= req_wr_adr[w1_idx];
        din_q[WIDTH +: WIDTH]        <= req_din[w1_idx];
      end
      read_q <= r_hit;
      if (r_hit) rd_adr_q <= req_rd_adr[r_idx];
    end
  end

  assign bus.write  = write_q;
  assign bus.wr_adr = wr_adr_q;
  assign bus.din    = din_q;
  assign bus.read   = read_q;
  assign bus.rd_adr = rd_adr_q;

  // Stage 0 is loaded alongside read_q; after RD_LAT shifts the entry sits in the exit slot
  // exactly in the cycle the memory raises rd_vld for it.
  logic [RD_LAT:0]   tag_v;
  logic [BITREQ-1:0] tag_id [RD_LAT+1];
  logic              exit_v;
  logic [BITREQ-1:0] exit_id;

  assign exit_v  = tag_v[RD_LAT];
  assign exit_id = tag_id[RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[RD_LAT-1:0], r_hit};
      tag_id[0] <= r_idx;
      for (int k = 1; k <= RD_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  logic [NUMREQ-1:0] rq_rd_vld_q;
  logic [WIDTH-1:0]  rq_rd_dout_q;
  logic              rq_rd_serr_q, rq_rd_derr_q, tag_err_q;

  // A return only fires when memory and tag pipe agree; any disagreement latches tag_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_rd_vld_q  <= '0;
      rq_rd_dout_q <= '0;
      rq_rd_serr_q <= 1'b0;
      rq_rd_derr_q <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      rq_rd_vld_q  <= '0;
      rq_rd_serr_q <= 1'b0;
      rq_rd_derr_q <= 1'b0;
      if (bus.rd_vld && exit_v) begin
        rq_rd_vld_q  <= NUMREQ'(1) << exit_id;
        rq_rd_dout_q <= bus.rd_dout;
        rq_rd_serr_q <= bus.rd_serr;
        rq_rd_derr_q <= bus.rd_derr;
      end
      if (bus.rd_vld != exit_v) tag_err_q <= 1'b1;
    end
  end

  assign bus.rq_rd_vld  = rq_rd_vld_q;
  assign bus.rq_rd_dout = rq_rd_dout_q;
  assign bus.rq_rd_serr = rq_rd_serr_q;
  assign bus.rq_rd_derr = rq_rd_derr_q;
  assign bus.tag_err    = tag_err_q;

endmodule
